// File: rtl/score_display_pkg.sv
// Shared types and default constants for the score display controller.
package score_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PLAY       = 2'd1,
    ST_OVER_SCORE = 2'd2,
    ST_OVER_BEST  = 2'd3
  } state_t;

  localparam int SCAN_DIV_DEF     = 1000;
  localparam int HOLD_TICKS_DEF   = 500;
  localparam int BLINK_TICKS_DEF  = 125;
  localparam int BLINK_PHASES_DEF = 6;

  // Bits needed to hold the values 0..n.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Prescaler: registered one-cycle tick every DIV clocks, first tick DIV clocks after reset.
module scan_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] TC = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == TC);
      cnt  <= (cnt == TC) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Score display sequencer: live score, then alternating final score / best.
// Optional record blink on the final-score phase is built when SCORE_BLINK_EN is defined.
module score_display_ctrl
  import score_display_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEF,
  parameter int HOLD_TICKS   = HOLD_TICKS_DEF,
  parameter int BLINK_TICKS  = BLINK_TICKS_DEF,
  parameter int BLINK_PHASES = BLINK_PHASES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_start,
  input  logic       game_over,
  input  logic [7:0] score,
  input  logic [7:0] best,
  output logic [7:0] disp_data,
  output logic       disp_blank,
  output logic       scan_en,
  output logic       new_record
);

  localparam int HW = cnt_w(HOLD_TICKS);
  localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_TICKS - 1);

  state_t        state, state_nxt;
  logic [7:0]    snap, snap_nxt, data_nxt;
  logic          nr_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (scan_en)
  );

  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    nr_nxt    = new_record;
    hold_nxt  = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (game_start) begin
          state_nxt = ST_PLAY;
          nr_nxt    = 1'b0;
        end
      end
      ST_PLAY: begin
        if (game_over) begin
          state_nxt = ST_OVER_SCORE;
          snap_nxt  = score;
          nr_nxt    = (score > best);
          hold_nxt  = '0;
        end
      end
      default: begin
        // Over states: a new round preempts the alternation, even on a tick cycle.
        if (game_start) begin
          state_nxt = ST_PLAY;
          nr_nxt    = 1'b0;
          hold_nxt  = '0;
        end else if (scan_en) begin
          if (hold_cnt >= HOLD_TC) begin
            state_nxt = (state == ST_OVER_SCORE) ? ST_OVER_BEST : ST_OVER_SCORE;
            hold_nxt  = '0;
          end else begin
            hold_nxt  = hold_cnt + HW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    data_nxt = best;
    case (state_nxt)
      ST_PLAY:       data_nxt = score;
      ST_OVER_SCORE: data_nxt = snap_nxt;
      default:       data_nxt = best;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      snap       <= '0;
      new_record <= 1'b0;
      hold_cnt   <= '0;
      disp_data  <= '0;
    end else begin
      state      <= state_nxt;
      snap       <= snap_nxt;
      new_record <= nr_nxt;
      hold_cnt   <= hold_nxt;
      disp_data  <= data_nxt;
    end
  end

`ifdef SCORE_BLINK_EN
  localparam int BW = cnt_w(BLINK_TICKS);
  localparam int PW = cnt_w(BLINK_PHASES);
  localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_TICKS - 1);
  localparam logic [PW-1:0] PH_MAX   = PW'(BLINK_PHASES);

  logic [BW-1:0] bcnt, bcnt_nxt;
  logic [PW-1:0] bph, bph_nxt;
  logic          blk_clr, blank_nxt;

  assign blk_clr = (state == ST_PLAY && game_over) ||
                   ((state == ST_OVER_SCORE || state == ST_OVER_BEST) && game_start);

  // Blink progress only moves during the final-score phase and is kept across OVER_BEST.
  always_comb begin
    bcnt_nxt = bcnt;
    bph_nxt  = bph;
    if (blk_clr) begin
      bcnt_nxt = '0;
      bph_nxt  = '0;
    end else if (state == ST_OVER_SCORE && scan_en && new_record && bph < PH_MAX) begin
      if (bcnt >= BLINK_TC) begin
        bcnt_nxt = '0;
        bph_nxt  = bph + PW'(1);
      end else begin
        bcnt_nxt = bcnt + BW'(1);
      end
    end
    blank_nxt = (state_nxt == ST_OVER_SCORE) && nr_nxt && (bph_nxt < PH_MAX) && !bph_nxt[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt       <= '0;
      bph        <= '0;
      disp_blank <= 1'b0;
    end else begin
      bcnt       <= bcnt_nxt;
      bph        <= bph_nxt;
      disp_blank <= blank_nxt;
    end
  end
`else
  assign disp_blank = 1'b0;
`endif

endmodule

// File: tb/tb_score_display_ctrl.sv
// Randomized self-checking bench for score_display_ctrl against a timeline-based reference model.
module tb_score_display_ctrl;

  localparam int DIV = 4;
  localparam int H   = 3;
  localparam int BT  = 2;
  localparam int PH  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       game_start = 1'b0;
  logic       game_over = 1'b0;
  logic [7:0] score = '0;
  logic [7:0] best = '0;
  logic [7:0] disp_data;
  logic       disp_blank, scan_en, new_record;

  score_display_ctrl #(
    .SCAN_DIV(DIV), .HOLD_TICKS(H), .BLINK_TICKS(BT), .BLINK_PHASES(PH)
  ) dut (
    .clk(clk), .reset(reset), .game_start(game_start), .game_over(game_over),
    .score(score), .best(best), .disp_data(disp_data), .disp_blank(disp_blank),
    .scan_en(scan_en), .new_record(new_record)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference: m_e = edges since release, m_mode 0 idle / 1 play / 2 over,
  // m_k = scan ticks elapsed since the round ended.
  int          m_e, m_mode, m_k;
  logic [7:0]  m_snap;
  logic        m_nr;
  logic [10:0] exp_v, got_v;

  task automatic model_reset();
    m_e = 0; m_mode = 0; m_k = 0; m_snap = '0; m_nr = 1'b0;
  endtask

  function automatic logic [10:0] model_out();
    logic [7:0] d;
    logic       b, s_en, win_score;
    int         s, half;
    b    = 1'b0;
    s_en = (m_e > 0) && (m_e % DIV == 0);
    d    = best;
    if (m_mode == 1) d = score;
    else if (m_mode == 2) begin
      win_score = ((m_k / H) % 2) == 0;
      d = win_score ? m_snap : best;
      // Ticks spent showing the final score so far; blink runs on that time only.
      s = (m_k / (2 * H)) * H + (((m_k % (2 * H)) < H) ? (m_k % (2 * H)) : H);
      half = s / BT;
`ifdef SCORE_BLINK_EN
      b = win_score && m_nr && (half < PH) && (half % 2 == 0);
`endif
    end
    return {d, b, s_en, m_nr};
  endfunction

  task automatic clk_step();
    bit tick;
    @(posedge clk);
    tick = (m_e > 0) && (m_e % DIV == 0);
    case (m_mode)
      0: if (game_start) begin m_mode = 1; m_nr = 1'b0; end
      1: if (game_over) begin m_mode = 2; m_k = 0; m_snap = score; m_nr = (score > best); end
      default: begin
        if (game_start) begin m_mode = 1; m_nr = 1'b0; end
        else if (tick) m_k++;
      end
    endcase
    m_e++;
    #1;
    exp_v = model_out();
    got_v = {disp_data, disp_blank, scan_en, new_record};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    vectors++;
    if ({disp_data, disp_blank, scan_en, new_record} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got data=%0d blank=%b scan=%b nr=%b, want all zero",
               disp_data, disp_blank, scan_en, new_record);
    end
    best = 8'd42;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 13; i++) begin
      clk_step();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL reset_release cyc %0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                 got_v[10:3], got_v[2], got_v[1], got_v[0], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_low_score();
    for (int i = 0; i < 80; i++) begin
      best       = 8'd42;
      game_start = (i == 0);
      score      = (i >= 1 && i <= 18) ? 8'(i - 1) : 8'($urandom);
      game_over  = (i == 18) || (i > 18 && $urandom_range(0, 3) == 0);
      clk_step();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL low_score cyc %0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                 got_v[10:3], got_v[2], got_v[1], got_v[0], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
    game_over = 1'b0;
  endtask

  task automatic test_record(input logic [7:0] sc, input logic [7:0] bs, input string nm);
    for (int i = 0; i < 130; i++) begin
      best       = bs;
      game_start = (i == 0);
      game_over  = (i == 2);
      score      = (i == 2) ? sc : 8'($urandom);
      clk_step();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s cyc %0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", nm, i,
                 got_v[10:3], got_v[2], got_v[1], got_v[0], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
    game_over = 1'b0;
  endtask

  task automatic test_simultaneous();
    bit done = 0;
    for (int i = 0; i < 120 && !done; i++) begin
      best = 8'd10;
      score = (i == 4) ? 8'd60 : 8'($urandom);
      game_start = (i == 0) || (i == 4);
      game_over  = (i == 4);
      // Once in the best-score phase, fire both pulses together.
      if (i > 4 && m_mode == 2 && ((m_k / H) % 2) == 1) begin
        game_start = 1'b1; game_over = 1'b1; done = 1;
      end
      clk_step();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL simultaneous cyc %0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                 got_v[10:3], got_v[2], got_v[1], got_v[0], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
    game_start = 1'b0; game_over = 1'b0;
    vectors++;
    if (!done || new_record !== 1'b0) begin
      errors++;
      $display("FAIL simultaneous_over_best: reached=%0d nr=%b, want reached=1 nr=0", done, new_record);
    end
  endtask

  task automatic test_reset_mid_blink();
    for (int i = 0; i < 12; i++) begin
      best = 8'd3; game_start = (i == 0); game_over = (i == 2);
      score = (i == 2) ? 8'd200 : 8'($urandom);
      clk_step();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL pre_reset cyc %0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                 got_v[10:3], got_v[2], got_v[1], got_v[0], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
    game_start = 1'b0; game_over = 1'b0;
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({disp_data, disp_blank, scan_en, new_record} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got data=%0d blank=%b scan=%b nr=%b, want all zero",
               disp_data, disp_blank, scan_en, new_record);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({disp_data, disp_blank, scan_en, new_record} !== 11'd0) begin
        errors++;
        $display("FAIL held_reset %0d: got data=%0d blank=%b nr=%b, want zero", i,
                 disp_data, disp_blank, new_record);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      best = 8'($urandom); score = 8'($urandom);
      clk_step();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL post_reset cyc %0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                 got_v[10:3], got_v[2], got_v[1], got_v[0], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      game_start = ($urandom_range(0, 15) == 0);
      game_over  = ($urandom_range(0, 7) == 0);
      score      = 8'($urandom);
      best       = ($urandom_range(0, 3) == 0) ? score : 8'($urandom);
      clk_step();
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc %0d: got %0d/%b/%b/%b want %0d/%b/%b/%b", i,
                 got_v[10:3], got_v[2], got_v[1], got_v[0], exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
    game_start = 1'b0; game_over = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_low_score();
    test_record(8'd50, 8'd42, "record_blink");
    test_simultaneous();
    test_record(8'd99, 8'd99, "tie_no_record");
    test_reset_mid_blink();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, clk cycles per scan_en pulse (>=2).
REQ-002 SHALL have parameter HOLD_TICKS, default 500, scan ticks per game-over alternation phase (>=1).
REQ-003 SHALL have parameter BLINK_TICKS, default 125, scan ticks per blink half-period (>=1).
REQ-004 SHALL have parameter BLINK_PHASES, default 6, blank/unblank toggles after a new record (>=0).
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-007 SHALL have port game_start  in  1  one-cycle pulse, round begins.
REQ-008 SHALL have port game_over  in  1  one-cycle pulse, round ends.
REQ-009 SHALL have port score  in  8  live score, unsigned.
REQ-010 SHALL have port best  in  8  stored best score, unsigned.
REQ-011 SHALL have port disp_data  out  8  value fed to the 7-segment driver.
REQ-012 SHALL have port disp_blank  out  1  1 = driver shall blank all anodes.
REQ-013 SHALL have port scan_en  out  1  one-cycle digit-advance strobe for the driver.
REQ-014 SHALL have port new_record  out  1  level, last finished round beat best.

Function
REQ-015 SHALL pulse scan_en high for exactly one cycle every SCAN_DIV cycles (prescaler terminal count SCAN_DIV-1, then wraps to 0); first pulse SCAN_DIV cycles after reset release.
REQ-016 SHALL implement FSM states ST_IDLE, ST_PLAY, ST_OVER_SCORE, ST_OVER_BEST; reset state ST_IDLE.
REQ-017 ST_IDLE: disp_data=best; game_start -> ST_PLAY; game_over ignored.
REQ-018 ST_PLAY: disp_data=score; game_over -> ST_OVER_SCORE, capture snap=score, new_record=(score>best, strict), hold and blink counters cleared; game_start ignored.
REQ-019 ST_OVER_SCORE: disp_data=snap; on HOLD_TICKS-th scan tick -> ST_OVER_BEST, hold counter cleared.
REQ-020 ST_OVER_BEST: disp_data=best; on HOLD_TICKS-th scan tick -> ST_OVER_SCORE, hold counter cleared; alternation continues indefinitely.
REQ-021 In either OVER state game_start SHALL go to ST_PLAY, clear new_record, disp_blank=0, counters cleared.
REQ-022 Simultaneous game_start and game_over: in ST_PLAY game_over wins; in all other states game_start wins.
REQ-023 All outputs SHALL be registered; disp_data reflects its source with exactly one cycle latency.
REQ-024 Hold/blink counters SHALL advance only on cycles where scan_en is high; they SHALL saturate, never wrap.
REQ-025 disp_blank SHALL be 0 in ST_IDLE, ST_PLAY and ST_OVER_BEST.

Reset
REQ-026 reset low SHALL immediately force: state ST_IDLE, disp_data=0, disp_blank=0, scan_en=0, new_record=0, snap=0, all counters 0.
REQ-027 Reset asserted mid-round or mid-blink SHALL abandon the round; no snapshot retained.
REQ-028 After release, disp_data=best from the first clock edge onward.

Configuration
REQ-029 Macro SCORE_BLINK_EN: when defined, in ST_OVER_SCORE with new_record=1, disp_blank SHALL toggle every BLINK_TICKS scan ticks, starting at 1, for BLINK_PHASES toggles total, then hold 0; blink progress persists across OVER_SCORE/OVER_BEST alternation.
REQ-030 Without SCORE_BLINK_EN, disp_blank SHALL be constant 0 and the blink counter SHALL not exist; new_record still functions.

Structure
REQ-031 Package score_display_pkg SHALL hold the state enum (2-bit) and default parameter constants.
REQ-032 Prescaler SHALL be sub-module scan_tick_gen (parameter DIV, outputs one-cycle tick).
REQ-033 RTL size target 150-300 lines including sub-module.

Verification (SCAN_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2, BLINK_PHASES=4)
REQ-034 Reset release, best=42 -> disp_data=42 next cycle, scan_en pulses at cycles 4,8,12.
REQ-035 game_start, score 0..17 ramp, game_over at score=17, best=42 -> disp_data 17 for 3 ticks, 42 for 3 ticks, repeating; new_record=0.
REQ-036 game_over with score=50, best=42, SCORE_BLINK_EN defined -> new_record=1, disp_blank 1,0,1,0 each 2 ticks then 0.
REQ-037 game_start and game_over same cycle in ST_PLAY -> ST_OVER_SCORE; same in ST_OVER_BEST -> ST_PLAY, new_record cleared.
REQ-038 reset low during blink -> disp_blank=0, disp_data=0 immediately (asynchronously, no clock edge needed), state ST_IDLE.
REQ-039 score=best=99 at game_over -> new_record=0 (strict compare), no blink.
